// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single regfile write port, plus a pending-write scoreboard.
// Optional macro WB_BYPASS_EN adds same-cycle forwarding of the value being written.
module regfile_wb_arbiter #(
   parameter int NUM_SRC = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   localparam int ID_W   = $clog2(NUM_SRC)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_SRC-1:0]        i_req_valid,
   input  logic [NUM_SRC*ADDR_W-1:0] i_req_addr,
   input  logic [NUM_SRC*DATA_W-1:0] i_req_data,
   output logic [NUM_SRC-1:0]        o_req_ready,
   output logic [ADDR_W-1:0]         o_rd_addr,
   output logic [DATA_W-1:0]         o_rd_data,
   output logic [ID_W-1:0]           o_grant_id,
   input  logic                      i_issue_valid,
   input  logic [ADDR_W-1:0]         i_issue_rd,
   input  logic [ADDR_W-1:0]         i_rs1_addr,
   input  logic [ADDR_W-1:0]         i_rs2_addr,
   output logic                      o_rs1_busy,
   output logic                      o_rs2_busy
`ifdef WB_BYPASS_EN
   ,
   output logic                      o_fwd1_hit,
   output logic                      o_fwd2_hit,
   output logic [DATA_W-1:0]         o_fwd1_data,
   output logic [DATA_W-1:0]         o_fwd2_data
`endif
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [ADDR_W-1:0]   addr_arr [NUM_SRC];
   logic [DATA_W-1:0]   data_arr [NUM_SRC];

   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic [DATA_W-1:0]   rd_data_q;
   logic [ID_W-1:0]     grant_id_q;
   logic [NUM_REGS-1:0] sb_q, sb_d;

   logic                found;
   logic                xfer;
   logic [ID_W-1:0]     win;
   logic [ID_W:0]       scan_sum;
   logic [ID_W-1:0]     scan_idx;

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
      assign addr_arr[k] = i_req_addr[k*ADDR_W +: ADDR_W];
      assign data_arr[k] = i_req_data[k*DATA_W +: DATA_W];
   end

   // Scan from the pointer, wrapping, and take the first valid source.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      found       = 1'b0;
      win         = '0;
      scan_sum    = '0;
      scan_idx    = '0;
      o_req_ready = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         scan_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
         if (scan_sum >= (ID_W+1)'(NUM_SRC)) begin
            scan_sum = scan_sum - (ID_W+1)'(NUM_SRC);
         end
         scan_idx = scan_sum[ID_W-1:0];
         if (!found && i_req_valid[scan_idx]) begin
            found = 1'b1;
            win   = scan_idx;
         end
      end
      xfer = found && !i_rst;
      if (xfer) begin
         o_req_ready[win] = 1'b1;
      end
      ptr_d = (win == ID_W'(NUM_SRC - 1)) ? '0 : win + ID_W'(1);
   end

   // Clear on landing write first, then set on issue, so a same-cycle set wins.
   always_comb begin
      sb_d = sb_q;
      if (rd_addr_q != '0) begin
         sb_d[rd_addr_q] = 1'b0;
      end
      if (i_issue_valid && (i_issue_rd != '0)) begin
         sb_d[i_issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (i_rst) begin
         rd_addr_q  <= '0;
         rd_data_q  <= '0;
         grant_id_q <= '0;
         ptr_q      <= '0;
         // NOTE: the scoreboard is a flop vector, not a RAM, and must be cleared so stale busy bits never stall issue.
         sb_q       <= '0;
      end else begin
         sb_q <= sb_d;
         if (xfer) begin
            rd_addr_q  <= addr_arr[win];
            rd_data_q  <= data_arr[win];
            grant_id_q <= win;
            ptr_q      <= ptr_d;
         end else begin
            rd_addr_q  <= '0;
         end
      end
   end

   assign o_rd_addr  = rd_addr_q;
   assign o_rd_data  = rd_data_q;
   assign o_grant_id = grant_id_q;

`ifdef WB_BYPASS_EN
   assign o_fwd1_hit  = (rd_addr_q != '0) && (rd_addr_q == i_rs1_addr);
   assign o_fwd2_hit  = (rd_addr_q != '0) && (rd_addr_q == i_rs2_addr);
   assign o_fwd1_data = rd_data_q;
   assign o_fwd2_data = rd_data_q;
   assign o_rs1_busy  = (i_rs1_addr != '0) && sb_q[i_rs1_addr] && !o_fwd1_hit;
   assign o_rs2_busy  = (i_rs2_addr != '0) && sb_q[i_rs2_addr] && !o_fwd2_hit;
`else
   assign o_rs1_busy  = (i_rs1_addr != '0) && sb_q[i_rs1_addr];
   assign o_rs2_busy  = (i_rs2_addr != '0) && sb_q[i_rs2_addr];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: table-driven arbitration vectors plus
// hand-written scoreboard, collision, address-0, bypass and mid-operation reset sequences.
module tb_regfile_wb_arbiter;

   localparam int NUM_SRC = 3;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;
   localparam int ID_W    = $clog2(NUM_SRC);
`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                      i_clk;
   logic                      i_rst;
   logic [NUM_SRC-1:0]        i_req_valid;
   logic [NUM_SRC*ADDR_W-1:0] i_req_addr;
   logic [NUM_SRC*DATA_W-1:0] i_req_data;
   logic [NUM_SRC-1:0]        o_req_ready;
   logic [ADDR_W-1:0]         o_rd_addr;
   logic [DATA_W-1:0]         o_rd_data;
   logic [ID_W-1:0]           o_grant_id;
   logic                      i_issue_valid;
   logic [ADDR_W-1:0]         i_issue_rd;
   logic [ADDR_W-1:0]         i_rs1_addr;
   logic [ADDR_W-1:0]         i_rs2_addr;
   logic                      o_rs1_busy;
   logic                      o_rs2_busy;
`ifdef WB_BYPASS_EN
   logic                      o_fwd1_hit;
   logic                      o_fwd2_hit;
   logic [DATA_W-1:0]         o_fwd1_data;
   logic [DATA_W-1:0]         o_fwd2_data;
`endif

   regfile_wb_arbiter #(
      .NUM_SRC (NUM_SRC),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_req_valid   (i_req_valid),
      .i_req_addr    (i_req_addr),
      .i_req_data    (i_req_data),
      .o_req_ready   (o_req_ready),
      .o_rd_addr     (o_rd_addr),
      .o_rd_data     (o_rd_data),
      .o_grant_id    (o_grant_id),
      .i_issue_valid (i_issue_valid),
      .i_issue_rd    (i_issue_rd),
      .i_rs1_addr    (i_rs1_addr),
      .i_rs2_addr    (i_rs2_addr),
      .o_rs1_busy    (o_rs1_busy),
      .o_rs2_busy    (o_rs2_busy)
`ifdef WB_BYPASS_EN
      ,
      .o_fwd1_hit    (o_fwd1_hit),
      .o_fwd2_hit    (o_fwd2_hit),
      .o_fwd1_data   (o_fwd1_data),
      .o_fwd2_data   (o_fwd2_data)
`endif
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   typedef struct {
      logic [2:0] v;
      logic [4:0] a0, a1, a2;
      logic [2:0] er;
   } vec_t;

   typedef struct {
      logic        xfer;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [1:0]  id;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] last_data = '0;
   int          n_pass    = 0;
   int          n_total   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Drive one request cycle, check the grant, queue the expected write, then check it after the edge.
   task automatic apply(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [2:0] er, input string nm);
      exp_t e;
      exp_t got;
      i_req_valid = v;
      i_req_addr  = {a2, a1, a0};
      i_req_data  = {d2, d1, d0};
      #1;
      check({nm, " ready"}, 64'(o_req_ready), 64'(er));
      e.xfer = |er;
      e.addr = '0;
      e.data = last_data;
      e.id   = '0;
      if (er[0]) begin e.addr = a0; e.data = d0; e.id = 2'd0; end
      if (er[1]) begin e.addr = a1; e.data = d1; e.id = 2'd1; end
      if (er[2]) begin e.addr = a2; e.data = d2; e.id = 2'd2; end
      last_data = e.data;
      exp_q.push_back(e);
      tick();
      got = exp_q.pop_front();
      check({nm, " rd_addr"}, 64'(o_rd_addr), 64'(got.addr));
      check({nm, " rd_data"}, 64'(o_rd_data), 64'(got.data));
      if (got.xfer) check({nm, " grant_id"}, 64'(o_grant_id), 64'(got.id));
   endtask

   vec_t tbl[10];

   initial begin
      tbl[0] = '{3'b111, 5'd5,  5'd6,  5'd7,  3'b001};
      tbl[1] = '{3'b111, 5'd5,  5'd6,  5'd7,  3'b010};
      tbl[2] = '{3'b111, 5'd5,  5'd6,  5'd7,  3'b100};
      tbl[3] = '{3'b111, 5'd5,  5'd6,  5'd7,  3'b001};
      tbl[4] = '{3'b000, 5'd5,  5'd6,  5'd7,  3'b000};
      tbl[5] = '{3'b101, 5'd10, 5'd11, 5'd12, 3'b100};
      tbl[6] = '{3'b110, 5'd10, 5'd11, 5'd12, 3'b010};
      tbl[7] = '{3'b011, 5'd10, 5'd11, 5'd12, 3'b001};
      tbl[8] = '{3'b001, 5'd13, 5'd14, 5'd15, 3'b001};
      tbl[9] = '{3'b100, 5'd13, 5'd14, 5'd15, 3'b100};

      i_rst         = 1'b1;
      i_req_valid   = 3'b111;
      i_req_addr    = {5'd7, 5'd6, 5'd5};
      i_req_data    = '0;
      i_issue_valid = 1'b0;
      i_issue_rd    = '0;
      i_rs1_addr    = 5'd9;
      i_rs2_addr    = 5'd5;

      // Reset held two cycles with every source requesting.
      tick();
      tick();
      check("reset ready", 64'(o_req_ready), 64'd0);
      check("reset rd_addr", 64'(o_rd_addr), 64'd0);
      check("reset rd_data", 64'(o_rd_data), 64'd0);
      check("reset grant_id", 64'(o_grant_id), 64'd0);
      check("reset rs1_busy", 64'(o_rs1_busy), 64'd0);
      check("reset rs2_busy", 64'(o_rs2_busy), 64'd0);
      i_rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         apply(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2,
               32'hA000_0000 | 32'(i << 8) | 32'd0,
               32'hA000_0000 | 32'(i << 8) | 32'd1,
               32'hA000_0000 | 32'(i << 8) | 32'd2,
               tbl[i].er, $sformatf("vec%0d", i));
      end

      // Issue rd=9, then source 1 writes 9; busy drops after the write lands.
      i_rs1_addr    = 5'd9;
      i_rs2_addr    = 5'd0;
      i_issue_valid = 1'b1;
      i_issue_rd    = 5'd9;
      #1;
      check("sb pre-issue busy", 64'(o_rs1_busy), 64'd0);
      apply(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b000, "sb issue");
      i_issue_valid = 1'b0;
      #1;
      check("sb busy after issue", 64'(o_rs1_busy), 64'd1);
      apply(3'b010, 5'd0, 5'd9, 5'd0, 32'd0, 32'hDEAD_BEEF, 32'd0, 3'b010, "sb write");
      check("sb busy while presented", 64'(o_rs1_busy), 64'(!BYP));
`ifdef WB_BYPASS_EN
      check("fwd1 hit", 64'(o_fwd1_hit), 64'd1);
      check("fwd1 data", 64'(o_fwd1_data), 64'hDEAD_BEEF);
`endif
      apply(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b000, "sb land");
      check("sb busy after land", 64'(o_rs1_busy), 64'd0);

      // Reissue 9 in the same cycle its write lands: set wins.
      i_issue_valid = 1'b1;
      i_issue_rd    = 5'd9;
      apply(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'b000, "col issue");
      i_issue_valid = 1'b0;
      apply(3'b001, 5'd9, 5'd0, 5'd0, 32'h5555_AAAA, 32'd0, 32'd0, 3'b001, "col write");
      i_issue_valid = 1'b1;
      i_issue_rd    = 5'd9;
      // Same edge also accepts an address-0 request from source 2.
      apply(3'b100, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h0000_1234, 3'b100, "addr0");
      i_issue_valid = 1'b0;
      #1;
      check("col busy holds", 64'(o_rs1_busy), 64'd1);
      check("addr0 rs2 busy", 64'(o_rs2_busy), 64'd0);

      // Pointer is back at 0; write 12 and look it up on rs2.
      i_issue_valid = 1'b1;
      i_issue_rd    = 5'd12;
      i_rs2_addr    = 5'd12;
      apply(3'b111, 5'd12, 5'd3, 5'd4, 32'hCAFE_0001, 32'd3, 32'd4, 3'b001, "byp write");
      i_issue_valid = 1'b0;
      #1;
      check("byp rs2 busy", 64'(o_rs2_busy), 64'(!BYP));
      check("byp rs1 busy", 64'(o_rs1_busy), 64'd1);
`ifdef WB_BYPASS_EN
      check("fwd2 hit", 64'(o_fwd2_hit), 64'd1);
      check("fwd2 data", 64'(o_fwd2_data), 64'hCAFE_0001);
      check("fwd1 miss", 64'(o_fwd1_hit), 64'd0);
`endif

      // Reset mid-operation with busy entries and pending requests.
      i_rst       = 1'b1;
      i_req_valid = 3'b111;
      i_req_addr  = {5'd7, 5'd6, 5'd5};
      #1;
      check("midrst ready", 64'(o_req_ready), 64'd0);
      tick();
      check("midrst rd_addr", 64'(o_rd_addr), 64'd0);
      check("midrst rs1 busy", 64'(o_rs1_busy), 64'd0);
      check("midrst rs2 busy", 64'(o_rs2_busy), 64'd0);
      i_rst     = 1'b0;
      last_data = '0;
      apply(3'b111, 5'd5, 5'd6, 5'd7, 32'h11, 32'h22, 32'h33, 3'b001, "post-rst");
      apply(3'b110, 5'd5, 5'd6, 5'd7, 32'h11, 32'h22, 32'h33, 3'b010, "post-rst2");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
